// File: rtl/adder_pipe.sv
// ---------------------------------------------------------------------------
// adder_pipe
//
// Pipelined ripple-carry adder with valid/ready handshaking on both sides.
// The WIDTH-bit operands are split into STAGES equal chunks. Each pipeline
// stage adds one chunk and registers the carry for the next stage. The
// operands still to be added travel alongside the carry, and the sum chunks
// already computed travel with them.
//
// All stages advance together whenever the output register is empty or is
// being drained this cycle. This gives full backpressure with a purely
// combinational in_ready.
//
// Parameters:
//   WIDTH   operand / sum width in bits (>= 2)
//   STAGES  number of pipeline stages (1..WIDTH, must divide WIDTH)
//
// Ports:
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   block accepts a beat this cycle
//   a, b       operands (unsigned or two's complement)
//   c_in       carry in
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   sum        a + b + c_in modulo 2^WIDTH
//   c_out      carry out of the MSB
//   ovf        signed overflow (carry into MSB xor carry out of MSB)
//   sub        (only with ADDER_PIPE_SUB_EN) compute a - b for this beat
//
// Optional feature macro: ADDER_PIPE_SUB_EN adds the 'sub' input.
// ---------------------------------------------------------------------------
module adder_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
`ifdef ADDER_PIPE_SUB_EN
  ,
  input  logic             sub
`endif
);

  localparam int CHUNK = WIDTH / STAGES;
  // The last stage needs no operand copy, so only STAGES-1 operand
  // registers exist. One slot is kept for the single-stage case.
  localparam int AB_DEPTH = (STAGES > 1) ? STAGES - 1 : 1;

  generate
    if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
      $error("adder_pipe: illegal WIDTH/STAGES combination");
    end
  endgenerate

  logic                adv;
  logic [STAGES-1:0]   st_valid;
  logic [STAGES-1:0]   st_carry;
  logic [WIDTH-1:0]    st_sum [STAGES];
  logic [WIDTH-1:0]    st_a   [AB_DEPTH];
  logic [WIDTH-1:0]    st_b   [AB_DEPTH];
  logic                ovf_q;

  logic [WIDTH-1:0]    b_eff;
  logic                c_eff;
  logic [CHUNK:0]      part;
  logic [STAGES-1:0]   nx_carry;
  logic [WIDTH-1:0]    nx_sum [STAGES];
  logic [WIDTH-1:0]    nx_a   [STAGES];
  logic [WIDTH-1:0]    nx_b   [STAGES];
  logic                nx_ovf;

  // The whole pipe moves as one: it advances when the output slot is free
  // or is being consumed in this cycle.
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = st_valid[STAGES-1];
  assign sum       = st_sum[STAGES-1];
  assign c_out     = st_carry[STAGES-1];
  assign ovf       = ovf_q;

  // Subtraction is a + ~b + 1. Inverting b at the entry lets the rest of
  // the pipe stay a plain adder, and the signed-overflow rule still holds
  // on the inverted operand.
  always_comb begin
    b_eff = b;
    c_eff = c_in;
`ifdef ADDER_PIPE_SUB_EN
    if (sub) begin
      b_eff = ~b;
      c_eff = 1'b1;
    end
`endif
  end

  // Per-stage chunk additions. Stage 0 works on the live inputs. Stage k
  // works on the operands and carry registered by stage k-1 and fills in
  // its own slice of the running sum. The carry into the MSB is recovered
  // as a^b^sum at the top bit, so ovf needs no extra carry chain.
  always_comb begin
    nx_carry = '0;
    part = {1'b0, a[CHUNK-1:0]} + {1'b0, b_eff[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_eff};
    nx_a[0]   = a;
    nx_b[0]   = b_eff;
    nx_sum[0] = '0;
    nx_sum[0][CHUNK-1:0] = part[CHUNK-1:0];
    nx_carry[0] = part[CHUNK];
    for (int k = 1; k < STAGES; k++) begin
      part = {1'b0, st_a[k-1][k*CHUNK +: CHUNK]} + {1'b0, st_b[k-1][k*CHUNK +: CHUNK]}
           + {{CHUNK{1'b0}}, st_carry[k-1]};
      nx_a[k]   = st_a[k-1];
      nx_b[k]   = st_b[k-1];
      nx_sum[k] = st_sum[k-1];
      nx_sum[k][k*CHUNK +: CHUNK] = part[CHUNK-1:0];
      nx_carry[k] = part[CHUNK];
    end
    nx_ovf = nx_a[STAGES-1][WIDTH-1] ^ nx_b[STAGES-1][WIDTH-1]
           ^ nx_sum[STAGES-1][WIDTH-1] ^ nx_carry[STAGES-1];
  end

  // Pipeline registers. Reset flushes every in-flight beat and clears the
  // visible result. Holding on !adv keeps a stalled result stable.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_valid <= '0;
      st_carry <= '0;
      ovf_q    <= 1'b0;
      for (int k = 0; k < STAGES; k++) st_sum[k] <= '0;
      for (int k = 0; k < AB_DEPTH; k++) begin
        st_a[k] <= '0;
        st_b[k] <= '0;
      end
    end else if (adv) begin
      st_valid[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) st_valid[k] <= st_valid[k-1];
      for (int k = 0; k < STAGES; k++) st_sum[k] <= nx_sum[k];
      for (int k = 0; k < STAGES - 1; k++) begin
        st_a[k] <= nx_a[k];
        st_b[k] <= nx_b[k];
      end
      st_carry <= nx_carry;
      ovf_q    <= nx_ovf;
    end
  end

endmodule

// File: tb/tb_adder_pipe.sv
// ---------------------------------------------------------------------------
// tb_adder_pipe
//
// Self-checking bench for adder_pipe. Expected results come from an
// integer-arithmetic reference model and are kept in an in-order queue.
// A result leaves the queue when the output handshake completes.
// ---------------------------------------------------------------------------
module tb_adder_pipe;

  localparam int WIDTH  = 8;
  localparam int STAGES = 2;
`ifdef ADDER_PIPE_SUB_EN
  localparam bit HAS_SUB = 1'b1;
`else
  localparam bit HAS_SUB = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rstn;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub_i;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             o;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   n_in         = 0;
  int   n_out        = 0;

  adder_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
`ifdef ADDER_PIPE_SUB_EN
    ,
    .sub       (sub_i)
`endif
  );

  always #5 clk = ~clk;

  // Abort if the run stalls well beyond its expected length.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference model: plain integer arithmetic on the operands' unsigned and
  // signed readings.
  function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic cv, input logic sv);
    int   m;
    int   ua;
    int   ub;
    int   sa;
    int   sb;
    int   full;
    int   sres;
    exp_t e;
    m  = 1 << WIDTH;
    ua = int'(av);
    ub = int'(bv);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (HAS_SUB && sv) begin
      full = ua + (m - 1 - ub) + 1;
      sres = sa - sb;
    end else begin
      full = ua + ub + int'(cv);
      sres = sa + sb + int'(cv);
    end
    e.s = WIDTH'(full % m);
    e.c = (full >= m);
    e.o = (sres >= m / 2) || (sres < -(m / 2));
    return e;
  endfunction

  task automatic applyStimulus(input logic iv, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                               input logic cv, input logic sv, input logic ordy);
    in_valid  = iv;
    a         = av;
    b         = bv;
    c_in      = cv;
    sub_i     = HAS_SUB ? sv : 1'b0;
    out_ready = ordy;
  endtask

  // One clock cycle. At the falling edge the handshake rule is checked.
  // Any visible result is compared with the oldest expected one. The
  // handshakes that the next rising edge will complete are then recorded.
  task automatic stepCycle();
    exp_t e;
    @(negedge clk);
    checkOutput("in_ready", in_ready, !out_valid || out_ready);
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_out", out_valid, 1'b0);
      end else begin
        e = exp_q[0];
        checkOutput("sum", sum, e.s);
        checkOutput("c_out", c_out, e.c);
        checkOutput("ovf", ovf, e.o);
        if (out_ready) begin
          void'(exp_q.pop_front());
          n_out++;
        end
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(model(a, b, c_in, sub_i));
      n_in++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    guard = 0;
    while (exp_q.size() > 0 && guard < 50) begin
      stepCycle();
      guard++;
    end
    checkOutput("drain_empty", exp_q.size(), 0);
  endtask

  // Single beat into an empty pipe. The bench checks the latency and
  // known constant results, then lets the scoreboard retire the beat.
  task automatic directedBeat(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                              input logic cv, input logic sv, input logic [WIDTH-1:0] exp_sum,
                              input logic exp_c, input logic exp_o);
    int lat;
    applyStimulus(1'b1, av, bv, cv, sv, 1'b1);
    stepCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    lat = 1;
    while (!out_valid && lat <= 4 * STAGES + 4) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({tag, "_latency"}, lat, STAGES);
    checkOutput({tag, "_sum"}, sum, exp_sum);
    checkOutput({tag, "_c_out"}, c_out, exp_c);
    checkOutput({tag, "_ovf"}, ovf, exp_o);
    stepCycle();
  endtask

  initial begin
    int base_in;
    int base_out;

    // Reset held for three cycles with a valid beat offered.
    rstn = 1'b0;
    applyStimulus(1'b1, 8'hA5, 8'h3C, 1'b1, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_out_valid", out_valid, 1'b0);
      checkOutput("rst_sum", sum, '0);
      checkOutput("rst_c_out", c_out, 1'b0);
      checkOutput("rst_ovf", ovf, 1'b0);
      checkOutput("rst_in_ready", in_ready, 1'b1);
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    stepCycle();

    // Carry across chunks and signed overflow.
    directedBeat("ff_plus_1", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    directedBeat("7f_plus_1", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    directedBeat("cin_only", 8'h0F, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0);
    directedBeat("neg_ovf", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    if (HAS_SUB) begin
      directedBeat("sub_5_7", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
      directedBeat("sub_7_5", 8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0);
    end
    drain();

    // Back-to-back streaming of 100 random beats. With out_ready held high,
    // exactly 100 results must leave in 100 + STAGES cycles.
    base_in  = n_in;
    base_out = n_out;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                    1'($urandom), 1'b1);
      stepCycle();
    end
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    repeat (STAGES) stepCycle();
    checkOutput("stream_in_count", n_in - base_in, 100);
    checkOutput("stream_out_count", n_out - base_out, 100);
    checkOutput("stream_empty", exp_q.size(), 0);

    // Random backpressure and random input gaps.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom), WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom));
      stepCycle();
    end
    drain();
    checkOutput("bp_in_out_balance", n_in, n_out);

    // Reset while two beats are in flight: the first is stalled at the
    // output and the second sits behind it.
    applyStimulus(1'b1, 8'h11, 8'h22, 1'b0, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 8'h33, 8'h44, 1'b1, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_reset_valid", out_valid, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("async_rst_out_valid", out_valid, 1'b0);
    checkOutput("async_rst_in_ready", in_ready, 1'b1);
    checkOutput("async_rst_sum", sum, '0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    repeat (10) stepCycle();

    // The pipe must still work normally after the flush.
    directedBeat("post_flush", 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0);
    checkOutput("final_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
